// File: rtl/clock24_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clock24_pkg
//  Description : Shared mode encoding for the 24-hour clock set controller.
//                The 2-bit mode value is driven straight out on the MODE port,
//                so the encoding is part of the external interface.
//  Revision    : 1.0  initial release
// ============================================================================
package clock24_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_RUN      = 2'd0;
  localparam mode_t MODE_SET_HOUR = 2'd1;
  localparam mode_t MODE_SET_MIN  = 2'd2;

  // True for either of the two time-setting modes.
  function automatic logic is_set_mode(input mode_t m);
    return (m == MODE_SET_HOUR) || (m == MODE_SET_MIN);
  endfunction

endpackage : clock24_pkg
`default_nettype wire

// File: rtl/btn_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : btn_sync_edge
//  Description : Multi-flop synchroniser for an asynchronous push-button level,
//                followed by a registered rising-edge detector.
//                The rise pulse is registered, so it asserts one cycle after
//                the synchronised level goes high.
//  Ports       : clk   - system clock
//                rst   - asynchronous active-high reset
//                din   - raw asynchronous button level
//                level - synchronised button level
//                rise  - one-cycle pulse on a synchronised rising edge
//  Revision    : 1.0  initial release
// ============================================================================
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_level_d;
  logic                   r_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync    <= '0;
      r_level_d <= 1'b0;
      r_rise    <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], din};
      r_level_d <= r_sync[SYNC_STAGES-1];
      r_rise    <= r_sync[SYNC_STAGES-1] & ~r_level_d;
    end
  end

  assign level = r_sync[SYNC_STAGES-1];
  assign rise  = r_rise;

endmodule : btn_sync_edge
`default_nettype wire

// File: rtl/clock_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clock_set_ctrl
//  Description : Mode/time-set controller for the 24-hour clock. Gates the
//                hh:mm:ss counter enables, applies push-button increments
//                (with auto-repeat) to the selected field, blanks the field
//                being set at the 2 Hz rate and times out back to RUN.
//  Ports       : clk        - system clock
//                rst        - asynchronous active-high reset
//                en1hz      - one-cycle pulse per second
//                sig2hz     - 2 Hz square wave (blink / repeat timebase)
//                btn_mode   - raw button: enter/leave set mode
//                btn_sel    - raw button: toggle hour/minute field
//                btn_up     - raw button: increment selected field
//                sec_carry  - seconds counter == 59
//                min_carry  - minutes counter == 59
//                sec_en     - seconds counter enable
//                min_en     - minutes counter enable
//                hour_en    - hours counter enable
//                sec_clr    - one-cycle clear of the seconds counter
//                blank_hour - blank hour digits
//                blank_min  - blank minute digits
//                mode       - current mode (RUN=0, SET_HOUR=1, SET_MIN=2)
//  Revision    : 1.0  initial release
// ============================================================================
module clock_set_ctrl
  import clock24_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int REPEAT_DELAY = 2,
  parameter int TIMEOUT_SEC  = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en1hz,
  input  logic       sig2hz,
  input  logic       btn_mode,
  input  logic       btn_sel,
  input  logic       btn_up,
  input  logic       sec_carry,
  input  logic       min_carry,
  output logic       sec_en,
  output logic       min_en,
  output logic       hour_en,
  output logic       sec_clr,
  output logic       blank_hour,
  output logic       blank_min,
  output logic [1:0] mode
);

  localparam logic [3:0] REP_DLY  = 4'(REPEAT_DELAY);
  localparam logic [3:0] REP_MAX  = 4'd15;
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT_SEC - 1);

  // --------------------------------------------------------------------------
  // Button synchronisers
  // --------------------------------------------------------------------------
  logic w_mode_lvl, w_p_mode;
  logic w_sel_lvl,  w_p_sel;
  logic w_up_lvl,   w_p_up;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mode (
    .clk   (clk),
    .rst   (rst),
    .din   (btn_mode),
    .level (w_mode_lvl),
    .rise  (w_p_mode)
  );

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sel (
    .clk   (clk),
    .rst   (rst),
    .din   (btn_sel),
    .level (w_sel_lvl),
    .rise  (w_p_sel)
  );

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_up (
    .clk   (clk),
    .rst   (rst),
    .din   (btn_up),
    .level (w_up_lvl),
    .rise  (w_p_up)
  );

  // --------------------------------------------------------------------------
  // Shared state and decode
  // --------------------------------------------------------------------------
  mode_t      r_state;
  mode_t      w_next;
  logic       r_sig2hz_d;
  logic [3:0] r_rep_cnt;
  logic [7:0] r_to_cnt;
  logic       r_hour_inc;
  logic       r_min_inc;
  logic       r_blank_hour;
  logic       r_blank_min;

  logic w_in_set;
  logic w_up_held;
  logic w_sig_rise;
  logic w_rep_inc;
  logic w_timeout;
  logic w_exit;
  logic w_inc;
  logic w_state_chg;

  assign w_in_set    = is_set_mode(r_state);
  assign w_up_held   = w_in_set & w_up_lvl;
  assign w_sig_rise  = sig2hz & ~r_sig2hz_d;
  assign w_rep_inc   = w_up_held & w_sig_rise & (r_rep_cnt >= REP_DLY);
  // Timeout fires on the tick that would bring the count to TIMEOUT_SEC.
  assign w_timeout   = w_in_set & en1hz & (r_to_cnt == TO_LAST);
  assign w_exit      = w_in_set & (w_p_mode | w_timeout);
  // MODE beats SEL beats UP; an increment coinciding with exit is dropped.
  assign w_inc       = w_in_set & (w_p_up | w_rep_inc) & ~w_p_sel & ~w_exit;
  assign w_state_chg = (w_next != r_state);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= MODE_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      MODE_RUN: begin
        if (w_p_mode) w_next = MODE_SET_HOUR;
      end
      MODE_SET_HOUR: begin
        if (w_exit)       w_next = MODE_RUN;
        else if (w_p_sel) w_next = MODE_SET_MIN;
      end
      MODE_SET_MIN: begin
        if (w_exit)       w_next = MODE_RUN;
        else if (w_p_sel) w_next = MODE_SET_HOUR;
      end
      default: w_next = MODE_RUN;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    sec_en  = 1'b0;
    min_en  = 1'b0;
    hour_en = 1'b0;
    sec_clr = 1'b0;
    case (r_state)
      MODE_RUN: begin
        sec_en  = en1hz;
        min_en  = en1hz & sec_carry;
        hour_en = en1hz & sec_carry & min_carry;
      end
      MODE_SET_HOUR, MODE_SET_MIN: begin
        // Time is held; only button increments reach the counters.
        hour_en = r_hour_inc;
        min_en  = r_min_inc;
        sec_clr = w_exit;
      end
      default: ;
    endcase
  end

  assign mode       = r_state;
  assign blank_hour = r_blank_hour;
  assign blank_min  = r_blank_min;

  // --------------------------------------------------------------------------
  // Auto-repeat, timeout, registered increment and blink
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig2hz_d   <= 1'b0;
      r_rep_cnt    <= 4'd0;
      r_to_cnt     <= 8'd0;
      r_hour_inc   <= 1'b0;
      r_min_inc    <= 1'b0;
      r_blank_hour <= 1'b0;
      r_blank_min  <= 1'b0;
    end else begin
      r_sig2hz_d <= sig2hz;

      if (!w_up_held || w_state_chg) begin
        r_rep_cnt <= 4'd0;
      end else if (w_sig_rise && (r_rep_cnt != REP_MAX)) begin
        r_rep_cnt <= r_rep_cnt + 4'd1;
      end

      // RUN keeps the counter at zero, which covers "cleared on entry".
      if (!w_in_set || w_p_mode || w_p_sel || w_p_up || w_up_held) begin
        r_to_cnt <= 8'd0;
      end else if (en1hz) begin
        r_to_cnt <= r_to_cnt + 8'd1;
      end

      r_hour_inc <= w_inc & (r_state == MODE_SET_HOUR);
      r_min_inc  <= w_inc & (r_state == MODE_SET_MIN);

      r_blank_hour <= (r_state == MODE_SET_HOUR) & sig2hz & ~w_up_lvl;
      r_blank_min  <= (r_state == MODE_SET_MIN)  & sig2hz & ~w_up_lvl;
    end
  end

endmodule : clock_set_ctrl
`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clock_set_ctrl
//  Description : Directed self-checking bench for clock_set_ctrl.
//                Pulse outputs are totalled by a negedge monitor; each test
//                compares the change in those totals with hand-derived counts.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_clock_set_ctrl;

  localparam int SYNC_STAGES  = 2;
  localparam int REPEAT_DELAY = 2;
  localparam int TIMEOUT_SEC  = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en1hz = 1'b0;
  logic       sig2hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_sel = 1'b0;
  logic       btn_up = 1'b0;
  logic       sec_carry = 1'b0;
  logic       min_carry = 1'b0;
  logic       sec_en, min_en, hour_en, sec_clr, blank_hour, blank_min;
  logic [1:0] mode;

  int n_tests = 0;
  int n_fail  = 0;

  // Running pulse totals, sampled on the falling edge.
  int tot_sec = 0, tot_min = 0, tot_hour = 0, tot_clr = 0;
  int s_sec, s_min, s_hour, s_clr;

  always #5 clk = ~clk;

  clock_set_ctrl #(
    .SYNC_STAGES  (SYNC_STAGES),
    .REPEAT_DELAY (REPEAT_DELAY),
    .TIMEOUT_SEC  (TIMEOUT_SEC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en1hz      (en1hz),
    .sig2hz     (sig2hz),
    .btn_mode   (btn_mode),
    .btn_sel    (btn_sel),
    .btn_up     (btn_up),
    .sec_carry  (sec_carry),
    .min_carry  (min_carry),
    .sec_en     (sec_en),
    .min_en     (min_en),
    .hour_en    (hour_en),
    .sec_clr    (sec_clr),
    .blank_hour (blank_hour),
    .blank_min  (blank_min),
    .mode       (mode)
  );

  always @(negedge clk) begin
    tot_sec  += int'(sec_en);
    tot_min  += int'(min_en);
    tot_hour += int'(hour_en);
    tot_clr  += int'(sec_clr);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_sec = tot_sec; s_min = tot_min; s_hour = tot_hour; s_clr = tot_clr;
  endtask

  task automatic tick1hz();
    en1hz = 1'b1;
    cyc(1);
    en1hz = 1'b0;
    cyc(1);
  endtask

  // 0 = MODE, 1 = SEL, 2 = UP
  task automatic press(input int b);
    case (b)
      0: btn_mode = 1'b1;
      1: btn_sel  = 1'b1;
      default: btn_up = 1'b1;
    endcase
    cyc(6);
    btn_mode = 1'b0;
    btn_sel  = 1'b0;
    btn_up   = 1'b0;
    cyc(6);
  endtask

  initial begin
    // ---------------- Reset ----------------
    cyc(3);
    check("rst_mode", int'(mode), 0);
    check("rst_outs", int'({sec_en, min_en, hour_en, sec_clr, blank_hour, blank_min}), 0);
    rst = 1'b0;
    cyc(2);

    // ---------------- 1: RUN enables ----------------
    sec_carry = 1'b1; min_carry = 1'b1; en1hz = 1'b1;
    #1;
    check("run_en_all", int'({sec_en, min_en, hour_en}), 3'b111);
    min_carry = 1'b0;
    #1;
    check("run_en_sec_carry", int'({sec_en, min_en, hour_en}), 3'b110);
    sec_carry = 1'b0;
    #1;
    check("run_en_nocarry", int'({sec_en, min_en, hour_en}), 3'b100);
    en1hz = 1'b0;
    #1;
    check("run_en_idle", int'({sec_en, min_en, hour_en}), 3'b000);
    cyc(1);

    // ---------------- 2: enter SET_HOUR, exact latency ----------------
    btn_mode = 1'b1;
    cyc(SYNC_STAGES + 1);
    check("mode_latency_before", int'(mode), 0);
    cyc(1);
    check("mode_latency_at", int'(mode), 1);
    btn_mode = 1'b0;
    cyc(6);
    snap();
    tick1hz();
    check("set_hold_sec", tot_sec - s_sec, 0);
    snap();
    press(2);
    check("set_hour_up_hour", tot_hour - s_hour, 1);
    check("set_hour_up_min", tot_min - s_min, 0);
    sig2hz = 1'b1;
    cyc(2);
    check("blink_hour_on", int'({blank_hour, blank_min}), 2'b10);
    sig2hz = 1'b0;
    cyc(2);
    check("blink_hour_off", int'({blank_hour, blank_min}), 2'b00);

    // ---------------- 3: SET_MIN with auto-repeat ----------------
    press(1);
    check("sel_to_min", int'(mode), 2);
    snap();
    btn_up = 1'b1;
    cyc(6);
    for (int i = 0; i < 5; i++) begin
      sig2hz = 1'b1;
      cyc(4);
      if (i == 0) check("blink_min_up_held", int'(blank_min), 0);
      sig2hz = 1'b0;
      cyc(4);
    end
    btn_up = 1'b0;
    cyc(6);
    check("repeat_min_pulses", tot_min - s_min, 4);
    check("repeat_hour_pulses", tot_hour - s_hour, 0);
    sig2hz = 1'b1;
    cyc(2);
    check("blink_min_on", int'({blank_hour, blank_min}), 2'b01);
    sig2hz = 1'b0;
    cyc(2);

    // ---------------- 4: leave via MODE ----------------
    snap();
    press(0);
    check("exit_mode", int'(mode), 0);
    check("exit_sec_clr", tot_clr - s_clr, 1);
    snap();
    tick1hz();
    check("run_resume_sec", tot_sec - s_sec, 1);

    // ---------------- 5: timeout ----------------
    press(0);
    check("reenter_hour", int'(mode), 1);
    snap();
    for (int i = 0; i < TIMEOUT_SEC - 1; i++) tick1hz();
    check("timeout_29_still_set", int'(mode), 1);
    tick1hz();
    check("timeout_30_run", int'(mode), 0);
    check("timeout_sec_clr", tot_clr - s_clr, 1);
    press(0);
    for (int i = 0; i < TIMEOUT_SEC - 1; i++) tick1hz();
    press(1);
    tick1hz();
    tick1hz();
    check("timeout_reset_by_sel", int'(mode), 2);

    // ---------------- 6: MODE+UP together, reset mid-set ----------------
    snap();
    btn_mode = 1'b1;
    btn_up   = 1'b1;
    cyc(6);
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    cyc(6);
    check("mode_up_exit", int'(mode), 0);
    check("mode_up_no_inc", tot_min - s_min, 0);
    check("mode_up_sec_clr", tot_clr - s_clr, 1);
    press(0);
    check("pre_reset_set", int'(mode), 1);
    snap();
    sig2hz = 1'b1;
    cyc(2);
    rst = 1'b1;
    #1;
    check("rst_mid_mode", int'(mode), 0);
    check("rst_mid_outs", int'({sec_en, min_en, hour_en, sec_clr, blank_hour, blank_min}), 0);
    cyc(2);
    rst = 1'b0;
    sig2hz = 1'b0;
    cyc(2);
    check("rst_mid_no_clr", tot_clr - s_clr, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_clock_set_ctrl
`default_nettype wire
